// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite single-outstanding master: turns a cmd/rsp handshake into one
// AXI4-Lite read or write at a time. All outputs come straight from flops.
module axi_4_lite_mst #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_TIMEOUT_CYCLES = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    // Command side
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    // Response side
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          timeout,
    // Write address channel
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    // Write data channel
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    // Write response channel
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    // Read address channel
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    // Read data channel
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP
);

    localparam int unsigned StrbW = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned CntW  = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(C_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StAr,
        StR,
        StRsp
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]      wstrb_q, wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;

        // Saturating wait counter; the transaction itself is never abandoned
        if (state_q == StWrite || state_q == StAr || state_q == StR) begin
            cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
            timeout_d = timeout_q | (cnt_d == CntMax);
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cnt_d       = '0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWrite;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StAr;
                    end
                end
            end
            StWrite: begin
                aw_done_d = aw_done_q | (awvalid_q & M_AXI_AWREADY);
                w_done_d  = w_done_q | (wvalid_q & M_AXI_WREADY);
                awvalid_d = ~aw_done_d;
                wvalid_d  = ~w_done_d;
                // An early B still ends the write; nothing is left pending
                if (M_AXI_BVALID && bready_q) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StAr: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StR;
                end
            end
            StR: begin
                if (M_AXI_RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout       = timeout_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Directed bench for axi_4_lite_mst with a small AXI4-Lite register-file slave.
module tb_axi_4_lite_mst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_4_lite_mst #(
        .C_AXI_ADDR_WIDTH(32),
        .C_AXI_DATA_WIDTH(32),
        .C_TIMEOUT_CYCLES(8)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .timeout      (timeout),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    int          aw_delay = 0;
    int          w_delay = 0;
    logic        ar_enable = 1'b1;
    logic [1:0]  resp_cfg = 2'b00;
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got, ar_got;
    logic [31:0] aw_addr_l, w_data_l;
    logic [3:0]  w_strb_l;

    assign awready = !aw_got && (aw_cnt >= aw_delay);
    assign wready  = !w_got && (w_cnt >= w_delay);
    assign arready = ar_enable && !ar_got;
    assign bresp   = resp_cfg;
    assign rresp   = resp_cfg;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            ar_got <= 1'b0;
            aw_cnt <= 0;
            w_cnt  <= 0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_got    <= 1'b1;
                aw_addr_l <= awaddr;
            end else if (awvalid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_got    <= 1'b1;
                w_data_l <= wdata;
                w_strb_l <= wstrb;
            end else if (wvalid && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (w_strb_l[b]) mem[aw_addr_l[5:2]][8*b +: 8] <= w_data_l[8*b +: 8];
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                aw_cnt <= 0;
                w_cnt  <= 0;
            end
            if (arvalid && arready) begin
                ar_got <= 1'b1;
                rvalid <= 1'b1;
                rdata  <= mem[araddr[5:2]];
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
                ar_got <= 1'b0;
            end
        end
    end

    // ---------------- protocol monitor / activity counters ----------------
    int          cyc = 0;
    int          aw_cyc = 0;
    int          w_cyc = 0;
    int          b_hs = 0;
    int          viol = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_addr_h, w_data_h, ar_addr_h;
    logic [3:0]  w_strb_h;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            ar_pend <= 1'b0;
        end else begin
            viol <= viol
                + int'(aw_pend && (!awvalid || awaddr !== aw_addr_h))
                + int'(w_pend && (!wvalid || wdata !== w_data_h || wstrb !== w_strb_h))
                + int'(ar_pend && (!arvalid || araddr !== ar_addr_h));
            aw_pend   <= awvalid && !awready;
            w_pend    <= wvalid && !wready;
            ar_pend   <= arvalid && !arready;
            aw_addr_h <= awaddr;
            w_data_h  <= wdata;
            w_strb_h  <= wstrb;
            ar_addr_h <= araddr;
            aw_cyc    <= aw_cyc + int'(awvalid);
            w_cyc     <= w_cyc + int'(wvalid);
            b_hs      <= b_hs + int'(bvalid && bready);
        end
    end

    // ---------------- stimulus helpers ----------------
    int          acc_cyc;
    int          rsp_cyc;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;

    // Returns at the falling edge right after the command is accepted
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit accepted = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!accepted) begin
            failures++;
            $display("FAIL cmd_accept: got no cmd_ready, want acceptance within 40 cycles");
        end
        @(negedge clk);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        rsp_cyc = cyc;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rsp_wait: got no rsp_valid, want one within 40 cycles");
        end
    endtask

    task automatic accept_rsp();
        got_rdata = rsp_rdata;
        got_resp  = rsp_resp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
        issue_cmd(wr, addr, data, strb);
        wait_rsp();
        accept_rsp();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout});
        end
        checks++;
        if ({awaddr, wdata, wstrb, rsp_rdata, rsp_resp} !== 102'b0) begin
            failures++;
            $display("FAIL reset_data: got awaddr=%h wdata=%h wstrb=%h rdata=%h resp=%b want all 0",
                     awaddr, wdata, wstrb, rsp_rdata, rsp_resp);
        end
        checks++;
        if ({awprot, arprot} !== 6'b0) begin
            failures++;
            $display("FAIL reset_prot: got %b want 000000", {awprot, arprot});
        end
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        checks++;
        if (got_resp !== 2'b00) begin
            failures++;
            $display("FAIL wr_resp: got %b want 00", got_resp);
        end
        do_txn(1'b0, 32'h4, 32'h0, 4'h0);
        checks++;
        if (got_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_data: got %h want deadbeef", got_rdata);
        end
        checks++;
        if (got_resp !== 2'b00) begin
            failures++;
            $display("FAIL rd_resp: got %b want 00", got_resp);
        end
        // Zero-wait read: accept edge A, rsp_valid registered at edge A+2
        checks++;
        if (rsp_cyc - acc_cyc !== 2) begin
            failures++;
            $display("FAIL rd_latency: got %0d edges want 2", rsp_cyc - acc_cyc);
        end
    endtask

    task automatic test_strobe();
        do_txn(1'b1, 32'h8, 32'h11223344, 4'hF);
        checks++;
        if (got_rdata !== 32'h0) begin
            failures++;
            $display("FAIL wr_rdata_zero: got %h want 00000000", got_rdata);
        end
        do_txn(1'b1, 32'h8, 32'hAABBCCDD, 4'h5);
        do_txn(1'b0, 32'h8, 32'h0, 4'h0);
        checks++;
        if (got_rdata !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL strobe_merge: got %h want 11bb33dd", got_rdata);
        end
    endtask

    task automatic test_aw_stall();
        int aw0, w0, b0;
        aw_delay = 3;
        resp_cfg = 2'b10;
        aw0 = aw_cyc;
        w0  = w_cyc;
        b0  = b_hs;
        do_txn(1'b1, 32'hC, 32'h5A5A5A5A, 4'hF);
        aw_delay = 0;
        resp_cfg = 2'b00;
        checks++;
        if (aw_cyc - aw0 !== 4) begin
            failures++;
            $display("FAIL stall_aw_cycles: got %0d want 4", aw_cyc - aw0);
        end
        checks++;
        if (w_cyc - w0 !== 1) begin
            failures++;
            $display("FAIL stall_w_cycles: got %0d want 1", w_cyc - w0);
        end
        checks++;
        if (b_hs - b0 !== 1) begin
            failures++;
            $display("FAIL stall_b_count: got %0d want 1", b_hs - b0);
        end
        checks++;
        if (got_resp !== 2'b10) begin
            failures++;
            $display("FAIL stall_bresp: got %b want 10", got_resp);
        end
        do_txn(1'b0, 32'hC, 32'h0, 4'h0);
        checks++;
        if (got_rdata !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL stall_readback: got %h want 5a5a5a5a", got_rdata);
        end
    endtask

    task automatic test_rsp_backpressure();
        issue_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp} !== {1'b1, 1'b0, 32'hDEADBEEF, 2'b00}) begin
                failures++;
                $display("FAIL hold_stable[%0d]: got valid=%b cmd_ready=%b rdata=%h resp=%b want 1 0 deadbeef 00",
                         i, rsp_valid, cmd_ready, rsp_rdata, rsp_resp);
            end
            @(negedge clk);
        end
        accept_rsp();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release: got valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        ar_enable = 1'b0;
        issue_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        repeat (7) @(negedge clk);
        checks++;
        if ({timeout, arvalid} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early: got timeout=%b arvalid=%b want 0 1", timeout, arvalid);
        end
        @(negedge clk);
        checks++;
        if ({timeout, arvalid} !== 2'b11) begin
            failures++;
            $display("FAIL timeout_set: got timeout=%b arvalid=%b want 1 1", timeout, arvalid);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({timeout, arvalid, araddr} !== {2'b11, 32'h4}) begin
            failures++;
            $display("FAIL timeout_hold: got timeout=%b arvalid=%b araddr=%h want 1 1 00000004",
                     timeout, arvalid, araddr);
        end
        ar_enable = 1'b1;
        wait_rsp();
        accept_rsp();
        checks++;
        if (got_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL timeout_late_data: got %h want deadbeef", got_rdata);
        end
        checks++;
        if ({timeout, cmd_ready} !== 2'b11) begin
            failures++;
            $display("FAIL timeout_sticky: got timeout=%b cmd_ready=%b want 1 1", timeout, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        aw_delay = 30;
        w_delay  = 30;
        issue_cmd(1'b1, 32'h10, 32'hCAFE0001, 4'hF);
        repeat (9) @(negedge clk);
        checks++;
        if ({wvalid, awvalid} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_before: got wvalid=%b awvalid=%b want 1 1", wvalid, awvalid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            failures++;
            $display("FAIL midrst_flags: got %b want 000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        checks++;
        if ({cmd_ready, timeout} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_ready_timeout: got cmd_ready=%b timeout=%b want 1 0",
                     cmd_ready, timeout);
        end
        rst_n    = 1'b1;
        aw_delay = 0;
        w_delay  = 0;
        do_txn(1'b1, 32'h10, 32'h0BADF00D, 4'hF);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0);
        checks++;
        if (got_rdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL midrst_recover: got %h want 0badf00d", got_rdata);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL protocol_stability: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_strobe();
        test_aw_stall();
        test_rsp_backpressure();
        test_timeout();
        test_reset_mid_write();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
